// File: rtl/id_bypass_stage_pkg.sv
// Shared decode-stage types and constants used by the bypass stage, its interface and the regfile.
package id_bypass_stage_pkg;

  localparam int INSTR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_NUM = 32;

  typedef logic [INSTR_W-1:0] word_t;
  typedef logic [$clog2(DEF_REG_NUM)-1:0] regidx_t;

  typedef struct packed {
    logic    en;
    logic    rdy;
    regidx_t idx;
    word_t   data;
  } fwd_src_t;

  localparam regidx_t REG_ZERO = '0;

endpackage

// File: rtl/id_bypass_stage_if.sv
// Bundle of fetch/decode, bypass, writeback and scoreboard signals for id_bypass_stage.
interface id_bypass_stage_if
  import id_bypass_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32,
  parameter int NUM_RD  = 2,
  parameter int NUM_FWD = 3
);
  localparam int RIDX_W = $clog2(REG_NUM);

  // f_valid marks a live fetch slot; it is captured into d_valid on every edge unless
  // stall_i holds the slot or flush_i (which wins over stall_i) turns it into a bubble.
  logic                     stall_i;
  logic                     flush_i;
  logic                     f_valid;
  word_t                    f_instr;
  word_t                    f_pc;
  logic                     d_valid;
  word_t                    d_instr;
  word_t                    d_pc;
  logic [NUM_RD*RIDX_W-1:0] rd_idx;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_FWD-1:0]        fwd_en;
  logic [NUM_FWD*RIDX_W-1:0] fwd_idx;
  logic [NUM_FWD-1:0]        fwd_rdy;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;
  logic                     wb_en;
  logic [RIDX_W-1:0]        wb_idx;
  logic [DATA_W-1:0]        wb_data;
  logic                     sb_set;
  logic [RIDX_W-1:0]        sb_idx;
  logic                     hazard_o;

  modport master (
    output stall_i, flush_i, f_valid, f_instr, f_pc, rd_idx,
           fwd_en, fwd_idx, fwd_rdy, fwd_data, wb_en, wb_idx, wb_data, sb_set, sb_idx,
    input  d_valid, d_instr, d_pc, rd_data, hazard_o
  );

  modport slave (
    input  stall_i, flush_i, f_valid, f_instr, f_pc, rd_idx,
           fwd_en, fwd_idx, fwd_rdy, fwd_data, wb_en, wb_idx, wb_data, sb_set, sb_idx,
    output d_valid, d_instr, d_pc, rd_data, hazard_o
  );

endinterface

// File: rtl/id_bypass_stage_regfile_mp.sv
// Multi-read, single-write register file with hardwired zero register and async clear.
module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32,
  parameter int NUM_RD  = 2,
  parameter int RIDX_W  = $clog2(REG_NUM)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wrEn,
  input  logic [RIDX_W-1:0]        wrIdx,
  input  logic [DATA_W-1:0]        wrData,
  input  logic [NUM_RD*RIDX_W-1:0] rdIdx,
  output logic [NUM_RD*DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] regs [REG_NUM];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < REG_NUM; r++) regs[r] <= '0;
    end else if (wrEn && wrIdx != '0) begin
      regs[wrIdx] <= wrData;
    end
  end

  always_comb begin
    rdData = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rdData[p*DATA_W +: DATA_W] = regs[rdIdx[p*RIDX_W +: RIDX_W]];
    end
  end

endmodule

// File: rtl/id_bypass_stage.sv
// Decode stage: IF/ID register, regfile, priority bypass and operand hazard detection.
// Optional pending-write scoreboard enabled by defining ID_SCOREBOARD_EN.
module id_bypass_stage
  import id_bypass_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32,
  parameter int NUM_RD  = 2,
  parameter int NUM_FWD = 3
) (
  input logic              clk,
  input logic              resetn,
  id_bypass_stage_if.slave bus
);

  localparam int RIDX_W = $clog2(REG_NUM);

  logic                     dValid;
  word_t                    dInstr;
  word_t                    dPc;
  logic [NUM_RD*DATA_W-1:0] rfData;
  logic [NUM_RD*DATA_W-1:0] rdDataC;
  logic [NUM_RD-1:0]        portHaz;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dValid <= 1'b0;
      dInstr <= '0;
      dPc    <= '0;
    end else if (bus.flush_i) begin
      dValid <= 1'b0;
      dInstr <= '0;
    end else if (!bus.stall_i) begin
      dValid <= bus.f_valid;
      dInstr <= bus.f_instr;
      dPc    <= bus.f_pc;
    end
  end

  regfile_mp #(
    .DATA_W (DATA_W),
    .REG_NUM(REG_NUM),
    .NUM_RD (NUM_RD),
    .RIDX_W (RIDX_W)
  ) u_regfile (
    .clk   (clk),
    .resetn(resetn),
    .wrEn  (bus.wb_en),
    .wrIdx (bus.wb_idx),
    .wrData(bus.wb_data),
    .rdIdx (bus.rd_idx),
    .rdData(rfData)
  );

`ifdef ID_SCOREBOARD_EN
  logic [REG_NUM-1:0] pending;

  // A set issued in the same cycle as a clearing writeback wins: it belongs to a newer producer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending <= '0;
    end else begin
      if (bus.wb_en && bus.wb_idx != '0) pending[bus.wb_idx] <= 1'b0;
      if (bus.sb_set && bus.sb_idx != '0) pending[bus.sb_idx] <= 1'b1;
    end
  end
`else
  logic unusedSb;
  assign unusedSb = ^{bus.sb_set, bus.sb_idx};
`endif

  always_comb begin : bypassNet
    logic [RIDX_W-1:0] idx;
    logic [DATA_W-1:0] val;
    logic              rdy;
    logic              fwdHit;
    logic              wbHit;
    logic              pendHit;
    rdDataC = '0;
    portHaz = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      idx     = bus.rd_idx[p*RIDX_W +: RIDX_W];
      wbHit   = bus.wb_en && (bus.wb_idx == idx);
      val     = wbHit ? bus.wb_data : rfData[p*DATA_W +: DATA_W];
      rdy     = 1'b1;
      fwdHit  = 1'b0;
      pendHit = 1'b0;
      // Walk oldest to youngest so the youngest matching source ends up selected.
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (bus.fwd_en[i] && bus.fwd_idx[i*RIDX_W +: RIDX_W] == idx) begin
          fwdHit = 1'b1;
          val    = bus.fwd_data[i*DATA_W +: DATA_W];
          rdy    = bus.fwd_rdy[i];
        end
      end
`ifdef ID_SCOREBOARD_EN
      pendHit = pending[idx];
`endif
      if (pendHit && !fwdHit && !wbHit) rdy = 1'b0;
      if (idx == '0) begin
        val = '0;
        rdy = 1'b1;
      end
      rdDataC[p*DATA_W +: DATA_W] = val;
      portHaz[p] = dValid && !rdy;
    end
  end

  assign bus.d_valid  = dValid;
  assign bus.d_instr  = dInstr;
  assign bus.d_pc     = dPc;
  assign bus.rd_data  = rdDataC;
  assign bus.hazard_o = |portHaz;

endmodule

// File: tb/tb_id_bypass_stage.sv
// Randomized and directed bench for id_bypass_stage against a behavioural decode-stage model.
module tb_id_bypass_stage;
  import id_bypass_stage_pkg::*;

  localparam int DW = 32;
  localparam int RN = 32;
  localparam int NR = 2;
  localparam int NF = 3;
  localparam int RW = 5;

  logic clk;
  logic resetn;
  int   passCnt;
  int   totalCnt;

  // model state
  logic [DW-1:0] mRegs [RN];
  bit            mPend [RN];
  logic          mValid;
  logic [31:0]   mInstr;
  logic [31:0]   mPc;

  id_bypass_stage_if #(.DATA_W(DW), .REG_NUM(RN), .NUM_RD(NR), .NUM_FWD(NF)) bus ();

  id_bypass_stage #(.DATA_W(DW), .REG_NUM(RN), .NUM_RD(NR), .NUM_FWD(NF)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int r = 0; r < RN; r++) begin
      mRegs[r] = '0;
      mPend[r] = 1'b0;
    end
    mValid = 1'b0;
    mInstr = '0;
    mPc    = '0;
  endtask

  // driver tasks
  task automatic clear_inputs();
    bus.stall_i  = 1'b0;
    bus.flush_i  = 1'b0;
    bus.f_valid  = 1'b0;
    bus.f_instr  = '0;
    bus.f_pc     = '0;
    bus.rd_idx   = '0;
    bus.fwd_en   = '0;
    bus.fwd_idx  = '0;
    bus.fwd_rdy  = '0;
    bus.fwd_data = '0;
    bus.wb_en    = 1'b0;
    bus.wb_idx   = '0;
    bus.wb_data  = '0;
    bus.sb_set   = 1'b0;
    bus.sb_idx   = '0;
  endtask

  task automatic set_fwd(input int i, input logic en, input logic rdy,
                         input logic [RW-1:0] idx, input logic [DW-1:0] data);
    bus.fwd_en[i]              = en;
    bus.fwd_rdy[i]             = rdy;
    bus.fwd_idx[i*RW +: RW]    = idx;
    bus.fwd_data[i*DW +: DW]   = data;
  endtask

  task automatic set_rd(input int p, input logic [RW-1:0] idx);
    bus.rd_idx[p*RW +: RW] = idx;
  endtask

  // advance one clock edge, updating the model from the inputs seen at that edge
  task automatic step();
    @(posedge clk);
    if (bus.wb_en && bus.wb_idx != 0) mRegs[bus.wb_idx] = bus.wb_data;
`ifdef ID_SCOREBOARD_EN
    if (bus.wb_en && bus.wb_idx != 0) mPend[bus.wb_idx] = 1'b0;
    if (bus.sb_set && bus.sb_idx != 0) mPend[bus.sb_idx] = 1'b1;
`endif
    if (bus.flush_i) begin
      mValid = 1'b0;
      mInstr = '0;
    end else if (!bus.stall_i) begin
      mValid = bus.f_valid;
      mInstr = bus.f_instr;
      mPc    = bus.f_pc;
    end
    #1;
  endtask

  // reference read: first (youngest) matching source, else same-cycle writeback, else register
  function automatic logic [DW-1:0] model_read(input logic [RW-1:0] idx, output bit haz);
    logic [DW-1:0] v;
    bit            found;
    bit            ok;
    found = 1'b0;
    ok    = 1'b1;
    haz   = 1'b0;
    if (idx == 0) return '0;
    v = mRegs[idx];
    if (bus.wb_en && bus.wb_idx == idx) v = bus.wb_data;
    for (int i = 0; i < NF; i++) begin
      if (!found && bus.fwd_en[i] && bus.fwd_idx[i*RW +: RW] == idx) begin
        found = 1'b1;
        v     = bus.fwd_data[i*DW +: DW];
        ok    = bus.fwd_rdy[i];
      end
    end
`ifdef ID_SCOREBOARD_EN
    if (!found && mPend[idx] && !(bus.wb_en && bus.wb_idx == idx)) ok = 1'b0;
`endif
    haz = mValid && !ok;
    return v;
  endfunction

  task automatic test_reset();
    totalCnt++;
    if (bus.d_valid !== 1'b0) $display("FAIL reset_d_valid: got %0b want 0", bus.d_valid);
    else passCnt++;
    totalCnt++;
    if (bus.d_instr !== 32'h0) $display("FAIL reset_d_instr: got %h want 0", bus.d_instr);
    else passCnt++;
    totalCnt++;
    if (bus.d_pc !== 32'h0) $display("FAIL reset_d_pc: got %h want 0", bus.d_pc);
    else passCnt++;
    totalCnt++;
    if (bus.hazard_o !== 1'b0) $display("FAIL reset_hazard: got %0b want 0", bus.hazard_o);
    else passCnt++;
  endtask

  task automatic test_fetch();
    logic [31:0] instr;
    instr = $urandom;
    bus.f_valid = 1'b1;
    bus.f_pc    = 32'hBFC0_0000;
    bus.f_instr = instr;
    step();
    totalCnt++;
    if (bus.d_valid !== 1'b1) $display("FAIL fetch_d_valid: got %0b want 1", bus.d_valid);
    else passCnt++;
    totalCnt++;
    if (bus.d_pc !== 32'hBFC0_0000) $display("FAIL fetch_d_pc: got %h want bfc00000", bus.d_pc);
    else passCnt++;
    totalCnt++;
    if (bus.d_instr !== instr) $display("FAIL fetch_d_instr: got %h want %h", bus.d_instr, instr);
    else passCnt++;
  endtask

  task automatic test_flush_stall();
    bus.f_pc    = 32'h0000_1000;
    bus.stall_i = 1'b1;
    bus.flush_i = 1'b1;
    step();
    totalCnt++;
    if (bus.d_valid !== 1'b0) $display("FAIL flush_wins_valid: got %0b want 0", bus.d_valid);
    else passCnt++;
    totalCnt++;
    if (bus.d_instr !== 32'h0) $display("FAIL flush_wins_instr: got %h want 0", bus.d_instr);
    else passCnt++;
    totalCnt++;
    if (bus.d_pc !== 32'hBFC0_0000) $display("FAIL flush_keeps_pc: got %h want bfc00000", bus.d_pc);
    else passCnt++;
    bus.flush_i = 1'b0;
    bus.stall_i = 1'b0;
    bus.f_pc    = 32'h0000_2000;
    step();
    bus.stall_i = 1'b1;
    bus.f_pc    = 32'h0000_3000;
    step();
    totalCnt++;
    if (bus.d_pc !== 32'h0000_2000) $display("FAIL stall_hold_pc: got %h want 00002000", bus.d_pc);
    else passCnt++;
    totalCnt++;
    if (bus.d_valid !== 1'b1) $display("FAIL stall_hold_valid: got %0b want 1", bus.d_valid);
    else passCnt++;
  endtask

  task automatic test_fwd_priority();
    set_fwd(0, 1'b1, 1'b1, 5'd5, 32'hA);
    set_fwd(1, 1'b1, 1'b1, 5'd5, 32'hB);
    set_fwd(2, 1'b0, 1'b1, 5'd5, 32'hC);
    set_rd(0, 5'd5);
    set_rd(1, 5'd5);
    #1;
    totalCnt++;
    if (bus.rd_data[31:0] !== 32'hA) $display("FAIL fwd_youngest_p0: got %h want a", bus.rd_data[31:0]);
    else passCnt++;
    totalCnt++;
    if (bus.rd_data[63:32] !== 32'hA) $display("FAIL fwd_youngest_p1: got %h want a", bus.rd_data[63:32]);
    else passCnt++;
    totalCnt++;
    if (bus.hazard_o !== 1'b0) $display("FAIL fwd_no_hazard: got %0b want 0", bus.hazard_o);
    else passCnt++;
    set_fwd(1, 1'b1, 1'b0, 5'd5, 32'hB);
    #1;
    totalCnt++;
    if (bus.hazard_o !== 1'b0) $display("FAIL fwd_older_unready_ignored: got %0b want 0", bus.hazard_o);
    else passCnt++;
    set_fwd(0, 1'b0, 1'b1, 5'd5, 32'hA);
    set_fwd(1, 1'b1, 1'b1, 5'd5, 32'hB);
    #1;
    totalCnt++;
    if (bus.rd_data[31:0] !== 32'hB) $display("FAIL fwd_next_source: got %h want b", bus.rd_data[31:0]);
    else passCnt++;
    bus.fwd_en = '0;
  endtask

  task automatic test_hazard();
    set_fwd(0, 1'b1, 1'b0, 5'd8, 32'h88);
    set_rd(0, 5'd8);
    set_rd(1, 5'd0);
    #1;
    totalCnt++;
    if (bus.hazard_o !== 1'b1) $display("FAIL hazard_unready: got %0b want 1", bus.hazard_o);
    else passCnt++;
    set_rd(0, 5'd0);
    #1;
    totalCnt++;
    if (bus.hazard_o !== 1'b0) $display("FAIL hazard_r0: got %0b want 0", bus.hazard_o);
    else passCnt++;
    totalCnt++;
    if (bus.rd_data[31:0] !== 32'h0) $display("FAIL read_r0: got %h want 0", bus.rd_data[31:0]);
    else passCnt++;
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    set_rd(1, 5'd8);
    #1;
    totalCnt++;
    if (bus.hazard_o !== 1'b0) $display("FAIL hazard_bubble: got %0b want 0", bus.hazard_o);
    else passCnt++;
    bus.fwd_en  = '0;
    bus.stall_i = 1'b0;
    bus.f_valid = 1'b1;
    step();
    bus.stall_i = 1'b1;
  endtask

  task automatic test_writethrough();
    bus.rd_idx  = '0;
    bus.wb_en   = 1'b1;
    bus.wb_idx  = 5'd3;
    bus.wb_data = 32'h1234;
    set_rd(0, 5'd3);
    #1;
    totalCnt++;
    if (bus.rd_data[31:0] !== 32'h1234) $display("FAIL wb_through: got %h want 1234", bus.rd_data[31:0]);
    else passCnt++;
    step();
    bus.wb_idx  = 5'd0;
    bus.wb_data = 32'hFFFF;
    set_rd(1, 5'd0);
    #1;
    totalCnt++;
    if (bus.rd_data[31:0] !== 32'h1234) $display("FAIL wb_stored: got %h want 1234", bus.rd_data[31:0]);
    else passCnt++;
    step();
    bus.wb_en = 1'b0;
    #1;
    totalCnt++;
    if (bus.rd_data[63:32] !== 32'h0) $display("FAIL r0_stays_zero: got %h want 0", bus.rd_data[63:32]);
    else passCnt++;
  endtask

  task automatic test_async_reset();
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    totalCnt++;
    if (bus.d_valid !== 1'b0 || bus.d_pc !== 32'h0) $display("FAIL async_reset_ifid: got valid=%0b pc=%h want 0/0", bus.d_valid, bus.d_pc);
    else passCnt++;
    totalCnt++;
    if (bus.rd_data[31:0] !== 32'h0) $display("FAIL async_reset_rf: got %h want 0", bus.rd_data[31:0]);
    else passCnt++;
    #1;
    resetn = 1'b1;
    clear_inputs();
  endtask

`ifdef ID_SCOREBOARD_EN
  task automatic test_scoreboard();
    bus.f_valid = 1'b1;
    bus.stall_i = 1'b0;
    bus.sb_set  = 1'b1;
    bus.sb_idx  = 5'd9;
    step();
    bus.sb_set = 1'b0;
    bus.rd_idx = '0;
    set_rd(0, 5'd9);
    #1;
    totalCnt++;
    if (bus.hazard_o !== 1'b1) $display("FAIL sb_pending: got %0b want 1", bus.hazard_o);
    else passCnt++;
    step();
    totalCnt++;
    if (bus.hazard_o !== 1'b1) $display("FAIL sb_still_pending: got %0b want 1", bus.hazard_o);
    else passCnt++;
    bus.wb_en   = 1'b1;
    bus.wb_idx  = 5'd9;
    bus.wb_data = 32'h9999;
    #1;
    totalCnt++;
    if (bus.hazard_o !== 1'b0 || bus.rd_data[31:0] !== 32'h9999) $display("FAIL sb_wb_cycle: got haz=%0b data=%h want 0/9999", bus.hazard_o, bus.rd_data[31:0]);
    else passCnt++;
    step();
    bus.wb_en = 1'b0;
    #1;
    totalCnt++;
    if (bus.hazard_o !== 1'b0) $display("FAIL sb_cleared: got %0b want 0", bus.hazard_o);
    else passCnt++;
    bus.sb_set  = 1'b1;
    bus.sb_idx  = 5'd9;
    bus.wb_en   = 1'b1;
    bus.wb_idx  = 5'd9;
    step();
    bus.sb_set = 1'b0;
    bus.wb_en  = 1'b0;
    #1;
    totalCnt++;
    if (bus.hazard_o !== 1'b1) $display("FAIL sb_set_beats_clear: got %0b want 1", bus.hazard_o);
    else passCnt++;
    bus.wb_en = 1'b1;
    step();
    bus.wb_en = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [DW-1:0] expData;
    bit            portHaz;
    bit            expHaz;
    for (int n = 0; n < 300; n++) begin
      bus.stall_i = ($urandom_range(0, 5) == 0);
      bus.flush_i = ($urandom_range(0, 9) == 0);
      bus.f_valid = ($urandom_range(0, 3) != 0);
      bus.f_instr = $urandom;
      bus.f_pc    = $urandom;
      for (int p = 0; p < NR; p++) set_rd(p, RW'($urandom_range(0, 7)));
      for (int i = 0; i < NF; i++)
        set_fwd(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                RW'($urandom_range(0, 7)), $urandom);
      bus.wb_en   = 1'($urandom_range(0, 1));
      bus.wb_idx  = RW'($urandom_range(0, 7));
      bus.wb_data = $urandom;
      bus.sb_set  = ($urandom_range(0, 4) == 0);
      bus.sb_idx  = RW'($urandom_range(0, 7));
      #1;
      expHaz = 1'b0;
      for (int p = 0; p < NR; p++) begin
        expData = model_read(bus.rd_idx[p*RW +: RW], portHaz);
        expHaz  = expHaz | portHaz;
        totalCnt++;
        if (bus.rd_data[p*DW +: DW] !== expData)
          $display("FAIL rand_rd_data[%0d] iter %0d: got %h want %h", p, n, bus.rd_data[p*DW +: DW], expData);
        else passCnt++;
      end
      totalCnt++;
      if (bus.hazard_o !== expHaz) $display("FAIL rand_hazard iter %0d: got %0b want %0b", n, bus.hazard_o, expHaz);
      else passCnt++;
      step();
      totalCnt++;
      if (bus.d_valid !== mValid || bus.d_instr !== mInstr || bus.d_pc !== mPc)
        $display("FAIL rand_ifid iter %0d: got %0b/%h/%h want %0b/%h/%h", n, bus.d_valid, bus.d_instr, bus.d_pc, mValid, mInstr, mPc);
      else passCnt++;
    end
  endtask

  initial begin
    passCnt  = 0;
    totalCnt = 0;
    resetn   = 1'b0;
    clear_inputs();
    model_reset();
    #3;
    test_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    test_fetch();
    test_flush_stall();
    test_fwd_priority();
    test_hazard();
    test_writethrough();
    test_async_reset();
`ifdef ID_SCOREBOARD_EN
    test_scoreboard();
`endif
    test_random();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
